crypto_seq_ctrl: RTL
====================

// Module: crypto_seq_ctrl
// PURPOSE
//  Sequencer for the 4-bit nibble cipher datapath (data a,b,c,d + 4-bit key -> y3..y0).
//  Accepts a multi-nibble word, feeds it one nibble per cycle with a rolling key,
//  collects each nibble's result and reassembles the encrypted word.
//  Sits between a host (key load / start handshake) and one combinational cipher instance.
// PARAMETERS
//  NIBBLES  4  nibbles per word; word width = 4*NIBBLES; legal range 1..8
//  KEY_ROT  1  rotate-left amount applied to the working key after each nibble, taken mod 4;
//              0 = fixed key
// PORTS
//  clk       in   1          rising-edge clock
//  rst_n     in   1          asynchronous, active-low reset
//  key_load  in   1          load key_in into key register (IDLE only)
//  key_in    in   4          key value
//  start     in   1          begin encrypting word_in (IDLE only)
//  word_in   in   4*NIBBLES  plaintext word; nibble 0 = bits [3:0]
//  dp_data   out  4          nibble to datapath {a,b,c,d}
//  dp_key    out  4          key to datapath
//  dp_y      in   4          datapath result {y3,y2,y1,y0}; combinational, same cycle
//  word_out  out  4*NIBBLES  encrypted word
//  busy      out  1          high while in RUN or DONE
//  done      out  1          one-cycle pulse: word_out is valid
//  key_valid out  1          a key has been loaded since reset
//  key_err   out  1          one-cycle pulse: start with no valid key
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; key_reg, work_key, idx, word_out, dp_data, dp_key = 0;
//    busy, done, key_valid, key_err = 0.
//    Asserting reset mid-run aborts immediately; partial results are lost.
//  - FSM: IDLE -> RUN -> DONE -> IDLE. All outputs registered except dp_data/dp_key,
//    which decode from state/idx/word_reg/work_key.
//  - IDLE, key_load=1: key_reg<=key_in; key_valid<=1.
//  - IDLE, start=1, key_valid=1 (or key_load=1 in the same cycle): word_reg<=word_in;
//    work_key<=key (key_in when key_load=1, else key_reg); idx<=0; -> RUN.
//  - IDLE, start=1, no key available: key_err=1 for one cycle; remain IDLE.
//  - RUN, each cycle: dp_data=word_reg nibble idx; dp_key=work_key;
//    at clock edge: word_out nibble idx<=dp_y; work_key<=rotl(work_key,KEY_ROT); idx<=idx+1.
//    When idx==NIBBLES-1 -> DONE.
//  - DONE: done=1 for exactly one cycle, busy still 1; -> IDLE.
//  - Latency: start sampled at edge 0 -> done high in cycle NIBBLES+1. Back-to-back words
//    need one IDLE cycle, so throughput is NIBBLES+2 cycles/word.
//  - key_reg is never modified by RUN. Every word starts with the loaded key.
//  - start and key_load while busy=1: ignored; no error flagged.
//  - word_out: unwritten nibbles keep their previous values during RUN.
//    Value is stable from done until the next RUN overwrites it.
//  - Outside RUN: dp_data=0, dp_key=0.
//  - idx width = clog2(NIBBLES) (min 1); no wrap beyond NIBBLES-1.
// TESTING (bench models datapath as dp_y = dp_data ^ dp_key)
//  1. NIBBLES=4, KEY_ROT=1; load key 4'h1; start with word 16'h0000
//     -> keys 1,2,4,8; word_out=16'h8421; done in cycle 5.
//  2. Load key 4'hA; start with word 16'hFFFF -> keys A,5,A,5; word_out=16'hA5A5.
//     Repeat the start -> identical result (key_reg unchanged).
//  3. After reset, start with no key_load -> key_err one-cycle pulse; busy stays 0; word_out=0.
//  4. During RUN, pulse key_load with key 4'h3 and start with a new word
//     -> both ignored; result matches the first word; key_reg unchanged.
//  5. Drop rst_n at idx=2 -> all outputs 0 asynchronously; key_valid=0;
//     after release, start gives key_err.
//  6. KEY_ROT=0, key 4'h6, word 16'h1234, same-cycle key_load+start -> word_out=16'h7452.

Source files
------------

// File: rtl/crypto_seq_if.sv
// crypto_seq_if: host/datapath bundle; master = host+datapath, slave = sequencer
interface crypto_seq_if #(parameter int NIBBLES = 4);
  logic                   key_load;
  logic [3:0]             key_in;
  logic                   start;
  logic [4*NIBBLES-1:0]   word_in;
  logic [3:0]             dp_data;
  logic [3:0]             dp_key;
  logic [3:0]             dp_y;
  logic [4*NIBBLES-1:0]   word_out;
  logic                   busy;
  logic                   done;
  logic                   key_valid;
  logic                   key_err;
  modport master (
    output key_load, key_in, start, word_in, dp_y,
    input  dp_data, dp_key, word_out, busy, done, key_valid, key_err
  );
  modport slave (
    input  key_load, key_in, start, word_in, dp_y,
    output dp_data, dp_key, word_out, busy, done, key_valid, key_err
  );
endinterface

// File: rtl/crypto_seq_ctrl.sv
// crypto_seq_ctrl: feeds a word nibble-by-nibble with a rolling key into a combinational cipher and reassembles the result
// ports: clk, rst_n (async active-low); bus.slave carries key_load/key_in/start/word_in from the host,
// dp_data/dp_key/dp_y to and from the cipher, and word_out/busy/done/key_valid/key_err back to the host
module crypto_seq_ctrl #(
  parameter int NIBBLES = 4,
  parameter int KEY_ROT = 1
) (
  input logic        clk,
  input logic        rst_n,
  crypto_seq_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam int R  = KEY_ROT % 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state, state_d;
  logic [W-1:0]    word_reg;
  logic [3:0]      key_reg, work_key, rot_key;
  logic [IW-1:0]   idx;
  logic            has_key, accept, last;
  always_comb begin
    has_key     = bus.key_valid || bus.key_load;
    accept      = state == IDLE && bus.start && has_key;
    last        = idx == IW'(NIBBLES - 1);
    rot_key     = (work_key << R) | (work_key >> (4 - R));
    state_d     = state == IDLE ? (accept ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    bus.dp_data = state == RUN ? word_reg[idx*4 +: 4] : 4'h0;
    bus.dp_key  = state == RUN ? work_key : 4'h0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      word_reg      <= '0;
      key_reg       <= '0;
      work_key      <= '0;
      idx           <= '0;
      bus.word_out  <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.key_valid <= 1'b0;
      bus.key_err   <= 1'b0;
    end else begin
      state       <= state_d;
      bus.done    <= state == RUN && last;
      bus.key_err <= state == IDLE && bus.start && !has_key;
      if (state == IDLE && bus.key_load) begin
        key_reg       <= bus.key_in;
        bus.key_valid <= 1'b1;
      end
      if (accept) begin
        word_reg <= bus.word_in;
        work_key <= bus.key_load ? bus.key_in : key_reg;
        idx      <= '0;
        bus.busy <= 1'b1;
      end
      if (state == RUN) begin
        bus.word_out[idx*4 +: 4] <= bus.dp_y;
        work_key                 <= rot_key;
        idx                      <= last ? idx : idx + 1'b1;
      end
      if (state == DONE) bus.busy <= 1'b0;
    end
  end
endmodule
